bus_strobe_sync: RTL and testbench
==================================

BUS_STROBE_SYNC -- requirements
Module: bus_strobe_sync

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of flip-flops in the bus_cs_n_i synchronizer (legal values 2..3).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state is clocked on its rising edge.
REQ-003 SHALL have port reset_i, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port bus_cs_n_i, input, 1 bit: asynchronous chip-select strobe from the external bus, active-low.
REQ-005 SHALL have port bus_rd_nwr_i, input, 1 bit: 1 = read, 0 = write.
REQ-006 SHALL have port bus_reg_num_i, input, 4 bits: register number.
REQ-007 SHALL have port bus_bytesel_i, input, 1 bit: 0 = high byte, 1 = low byte.
REQ-008 SHALL have port bus_data_i, input, 8 bits: write data.
REQ-009 SHALL have port bus_data_o, output, 8 bits: read data.
REQ-010 SHALL have port rd_word_i, input, 16 bits: register read value supplied by the downstream register block for reg_num_o.
REQ-011 SHALL have port write_strobe_o, output, 1 bit: one-cycle write pulse.
REQ-012 SHALL have port read_strobe_o, output, 1 bit: one-cycle read pulse.
REQ-013 SHALL have port reg_num_o, output, 4 bits: latched register number.
REQ-014 SHALL have port bytesel_o, output, 1 bit: latched byte select.
REQ-015 SHALL have port bytedata_o, output, 8 bits: latched write byte.

Function
REQ-016 SHALL pass bus_cs_n_i through a SYNC_STAGES-deep flip-flop chain; the chain output is cs_sync.
REQ-017 SHALL detect an access start when cs_sync is 0 and its registered previous value is 1.
REQ-018 SHALL sample bus_rd_nwr_i, bus_reg_num_i, bus_bytesel_i and bus_data_i raw on the access-start edge, into reg_num_o, bytesel_o and bytedata_o.
- Bus protocol guarantees these inputs are stable for at least 2 clk before and throughout CS low.
REQ-019 SHALL assert exactly one of write_strobe_o or read_strobe_o for exactly one clk, on the cycle after the access-start edge.
- Latency: SYNC_STAGES+2 rising edges after the first edge that samples bus_cs_n_i low.
REQ-020 SHALL generate exactly one strobe per CS low period, however long CS stays low; a new strobe requires cs_sync to return to 1 first.
REQ-021 SHALL register bus_data_o, during the read-strobe cycle, as rd_word_i[15:8] when bytesel_o=0, else rd_word_i[7:0].
- bus_data_o is valid from the cycle after read_strobe_o and holds until the next read strobe.
REQ-022 SHALL leave reg_num_o, bytesel_o, bytedata_o and bus_data_o unchanged between accesses.
REQ-023 SHALL never assert write_strobe_o and read_strobe_o in the same cycle.

Reset
REQ-024 SHALL clear write_strobe_o, read_strobe_o, reg_num_o, bytesel_o, bytedata_o and bus_data_o to 0 immediately on reset_i assertion.
REQ-025 SHALL reset all synchronizer flip-flops and the previous-value register to 0 ("CS asserted").
- An access still in progress when reset releases produces no strobe; the next strobe needs a CS high-then-low.

Configuration
REQ-026 SHALL, when macro BUS_DEGLITCH_EN is defined, require cs_sync to be 0 for 2 consecutive clk before declaring access start.
- Latency grows by 1 clk.
- A CS low pulse shorter than 2 synchronized samples produces no strobe.
REQ-027 SHALL, without BUS_DEGLITCH_EN, declare access start on the first cs_sync low sample, per REQ-017.

Structure
REQ-028 SHALL take register-number constants and a bus-access type enum (IDLE/WRITE/READ) from shared package xosera_pkg.
REQ-029 SHALL instantiate one sub-module, bus_sync_ff: a parameterized-depth synchronizer with asynchronous reset value 0.

Verification
REQ-030 Write access: reg 4'h1, bytesel 0, data 8'hAB, CS low 333 ns -> one write_strobe_o pulse at edge SYNC_STAGES+2; reg_num_o=1, bytesel_o=0, bytedata_o=8'hAB.
REQ-031 Read access: rd_word_i=16'hDA7A, bytesel 1 -> one read_strobe_o pulse; bus_data_o=8'h7A on the next cycle. Repeat with bytesel 0 -> 8'hDA.
REQ-032 CS held low for 1 ms -> exactly one strobe; CS high then low again -> a second strobe.
REQ-033 Reset pulse while CS is low -> all outputs 0 at once; no strobe until CS goes high then low.
REQ-034 With BUS_DEGLITCH_EN, a 1-clk CS low pulse -> no strobe; without the macro, a pulse of 1 clk plus synchronizer margin -> one strobe.
REQ-035 Back-to-back write then read, 4 x 83.333 ns apart -> two strobes in order, never overlapping; latched fields match each access.

Source files
------------

// File: rtl/xosera_pkg.sv
// Shared bus definitions: register numbers and the bus-access type used by bus_strobe_sync.
package xosera_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } bus_access_t;

    localparam logic [3:0] XM_XR_ADDR   = 4'h0;
    localparam logic [3:0] XM_XR_DATA   = 4'h1;
    localparam logic [3:0] XM_RD_INCR   = 4'h2;
    localparam logic [3:0] XM_RD_ADDR   = 4'h3;
    localparam logic [3:0] XM_WR_INCR   = 4'h4;
    localparam logic [3:0] XM_WR_ADDR   = 4'h5;
    localparam logic [3:0] XM_DATA      = 4'h6;
    localparam logic [3:0] XM_DATA_2    = 4'h7;
    localparam logic [3:0] XM_SYS_CTRL  = 4'h8;
    localparam logic [3:0] XM_TIMER     = 4'h9;
    localparam logic [3:0] XM_LAST      = 4'hF;

endpackage

// File: rtl/bus_sync_ff.sv
// Parameterized-depth flip-flop synchronizer; every stage resets asynchronously to 0.
module bus_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d};
        end
    end

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/bus_strobe_sync.sv
// Turns an asynchronous active-low bus chip-select into one-cycle read/write strobes with latched fields.
// Optional macro BUS_DEGLITCH_EN: require two consecutive synchronized low samples before an access starts.
module bus_strobe_sync
    import xosera_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic        bus_cs_n_i,
    input  logic        bus_rd_nwr_i,
    input  logic [3:0]  bus_reg_num_i,
    input  logic        bus_bytesel_i,
    input  logic [7:0]  bus_data_i,
    output logic [7:0]  bus_data_o,
    input  logic [15:0] rd_word_i,
    output logic        write_strobe_o,
    output logic        read_strobe_o,
    output logic [3:0]  reg_num_o,
    output logic        bytesel_o,
    output logic [7:0]  bytedata_o
);

    logic        cs_sync;
    logic        access_start;
    bus_access_t access_reg;

    bus_sync_ff #(
        .STAGES(SYNC_STAGES)
    ) cs_sync_ff (
        .clk(clk),
        .rst(reset_i),
        .d  (bus_cs_n_i),
        .q  (cs_sync)
    );

`ifdef BUS_DEGLITCH_EN
    // [0] = previous cs_sync, [1] = the one before; start needs high, low, low.
    logic [1:0] cs_hist_reg;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            cs_hist_reg <= 2'b00;
        end else begin
            cs_hist_reg <= {cs_hist_reg[0], cs_sync};
        end
    end

    assign access_start = !cs_sync && !cs_hist_reg[0] && cs_hist_reg[1];
`else
    logic cs_prev_reg;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            cs_prev_reg <= 1'b0;
        end else begin
            cs_prev_reg <= cs_sync;
        end
    end

    assign access_start = !cs_sync && cs_prev_reg;
`endif

    // Bus fields are sampled raw: the protocol holds them stable well before CS falls.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            access_reg <= IDLE;
            reg_num_o  <= 4'h0;
            bytesel_o  <= 1'b0;
            bytedata_o <= 8'h00;
        end else if (access_start) begin
            access_reg <= bus_rd_nwr_i ? READ : WRITE;
            reg_num_o  <= bus_reg_num_i;
            bytesel_o  <= bus_bytesel_i;
            bytedata_o <= bus_data_i;
        end else begin
            access_reg <= IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            write_strobe_o <= 1'b0;
            read_strobe_o  <= 1'b0;
        end else begin
            write_strobe_o <= (access_reg == WRITE);
            read_strobe_o  <= (access_reg == READ);
        end
    end

    // The register block presents rd_word_i during the read-strobe cycle.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            bus_data_o <= 8'h00;
        end else if (read_strobe_o) begin
            bus_data_o <= bytesel_o ? rd_word_i[7:0] : rd_word_i[15:8];
        end
    end

endmodule

// File: tb/tb_bus_strobe_sync.sv
// Self-checking bench for bus_strobe_sync: per-cycle model comparison plus directed literal checks.
module tb_bus_strobe_sync;

    localparam int N = 2;
`ifdef BUS_DEGLITCH_EN
    localparam bit DG  = 1'b1;
    localparam int LAT = N + 3;
`else
    localparam bit DG  = 1'b0;
    localparam int LAT = N + 2;
`endif

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        bus_cs_n_i = 1'b1;
    logic        bus_rd_nwr_i = 1'b0;
    logic [3:0]  bus_reg_num_i = 4'h0;
    logic        bus_bytesel_i = 1'b0;
    logic [7:0]  bus_data_i = 8'h00;
    logic [7:0]  bus_data_o;
    logic [15:0] rd_word_i = 16'h0000;
    logic        write_strobe_o;
    logic        read_strobe_o;
    logic [3:0]  reg_num_o;
    logic        bytesel_o;
    logic [7:0]  bytedata_o;

    bus_strobe_sync #(.SYNC_STAGES(N)) dut (
        .clk           (clk),
        .reset_i       (reset_i),
        .bus_cs_n_i    (bus_cs_n_i),
        .bus_rd_nwr_i  (bus_rd_nwr_i),
        .bus_reg_num_i (bus_reg_num_i),
        .bus_bytesel_i (bus_bytesel_i),
        .bus_data_i    (bus_data_i),
        .bus_data_o    (bus_data_o),
        .rd_word_i     (rd_word_i),
        .write_strobe_o(write_strobe_o),
        .read_strobe_o (read_strobe_o),
        .reg_num_o     (reg_num_o),
        .bytesel_o     (bytesel_o),
        .bytedata_o    (bytedata_o)
    );

    always #20 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_w = 0;
    int n_r = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: history of CS as sampled on each edge, bit 0 = newest; reset counts as "CS low".
    logic [7:0] cs_h = 8'h00;
    logic       m_rd = 1'b0;
    logic       exp_w = 1'b0, exp_r = 1'b0, exp_bs = 1'b0;
    logic [3:0] exp_reg = 4'h0;
    logic [7:0] exp_bd = 8'h00, exp_do = 8'h00;

    // Access begins when the bus went high then stayed low long enough to pass the synchronizer.
    function automatic logic started(input logic [7:0] h, input int off);
        if (DG) return !h[N+off] && !h[N+1+off] && h[N+2+off];
        else    return !h[N+off] && h[N+1+off];
    endfunction

    always @(posedge clk or posedge reset_i) begin : model
        logic [7:0] ncs;
        if (reset_i) begin
            cs_h    <= 8'h00;
            m_rd    <= 1'b0;
            exp_w   <= 1'b0;
            exp_r   <= 1'b0;
            exp_bs  <= 1'b0;
            exp_reg <= 4'h0;
            exp_bd  <= 8'h00;
            exp_do  <= 8'h00;
        end else begin
            ncs = {cs_h[6:0], bus_cs_n_i};
            exp_w <= started(ncs, 1) && !m_rd;
            exp_r <= started(ncs, 1) && m_rd;
            if (exp_r) exp_do <= exp_bs ? rd_word_i[7:0] : rd_word_i[15:8];
            if (started(ncs, 0)) begin
                m_rd    <= bus_rd_nwr_i;
                exp_reg <= bus_reg_num_i;
                exp_bs  <= bus_bytesel_i;
                exp_bd  <= bus_data_i;
            end
            cs_h <= ncs;
        end
    end

    always @(negedge clk) begin
        check("write_strobe", 32'(write_strobe_o), 32'(exp_w));
        check("read_strobe",  32'(read_strobe_o),  32'(exp_r));
        check("reg_num",      32'(reg_num_o),      32'(exp_reg));
        check("bytesel",      32'(bytesel_o),      32'(exp_bs));
        check("bytedata",     32'(bytedata_o),     32'(exp_bd));
        check("bus_data",     32'(bus_data_o),     32'(exp_do));
        if (write_strobe_o && read_strobe_o) check("strobe_overlap", 32'd1, 32'd0);
        if (write_strobe_o === 1'b1) n_w++;
        if (read_strobe_o === 1'b1) n_r++;
    end

    task automatic access(input logic rd, input logic [3:0] rn, input logic bs, input logic [7:0] d,
                          input int low, output int lat, output int nstb);
        bus_rd_nwr_i  = rd;
        bus_reg_num_i = rn;
        bus_bytesel_i = bs;
        bus_data_i    = d;
        repeat (3) @(negedge clk);
        bus_cs_n_i = 1'b0;
        lat  = 0;
        nstb = 0;
        for (int i = 1; i <= low + 12; i++) begin
            @(negedge clk);
            if (write_strobe_o || read_strobe_o) begin
                nstb++;
                if (lat == 0) lat = i;
            end
            if (i == low) bus_cs_n_i = 1'b1;
        end
    endtask

    initial begin
        int lat, nstb, w0, r0;

        repeat (3) @(negedge clk);
        check("rst_write_strobe", 32'(write_strobe_o), 32'd0);
        check("rst_read_strobe",  32'(read_strobe_o),  32'd0);
        check("rst_reg_num",      32'(reg_num_o),      32'd0);
        check("rst_bus_data",     32'(bus_data_o),     32'd0);
        reset_i = 1'b0;
        repeat (6) @(negedge clk);

        // Write access, CS low ~333 ns
        w0 = n_w;
        access(1'b0, 4'h1, 1'b0, 8'hAB, 8, lat, nstb);
        check("wr_latency",  32'(lat), 32'(LAT));
        check("wr_nstrobe",  32'(nstb), 32'd1);
        check("wr_is_write", 32'(n_w - w0), 32'd1);
        check("wr_reg_num",  32'(reg_num_o), 32'h1);
        check("wr_bytesel",  32'(bytesel_o), 32'h0);
        check("wr_bytedata", 32'(bytedata_o), 32'hAB);

        // Reads of both bytes
        rd_word_i = 16'hDA7A;
        r0 = n_r;
        access(1'b1, 4'h2, 1'b1, 8'h00, 8, lat, nstb);
        check("rd_lo_nstrobe", 32'(nstb), 32'd1);
        check("rd_lo_data",    32'(bus_data_o), 32'h7A);
        access(1'b1, 4'h3, 1'b0, 8'h00, 8, lat, nstb);
        check("rd_hi_data",    32'(bus_data_o), 32'hDA);
        check("rd_count",      32'(n_r - r0), 32'd2);

        // CS held low for 1 ms, then a fresh access
        access(1'b0, 4'h4, 1'b1, 8'h5C, 25000, lat, nstb);
        check("long_nstrobe", 32'(nstb), 32'd1);
        access(1'b0, 4'h4, 1'b0, 8'h3D, 8, lat, nstb);
        check("second_nstrobe", 32'(nstb), 32'd1);

        // Reset while CS low: immediate clear, no strobe until CS toggles
        access(1'b0, 4'h5, 1'b1, 8'h55, 30, lat, nstb);
        bus_cs_n_i = 1'b0;
        repeat (10) @(negedge clk);
        #5 reset_i = 1'b1;
        #1;
        check("arst_reg_num",  32'(reg_num_o),  32'd0);
        check("arst_bytesel",  32'(bytesel_o),  32'd0);
        check("arst_bytedata", 32'(bytedata_o), 32'd0);
        check("arst_bus_data", 32'(bus_data_o), 32'd0);
        @(negedge clk);
        reset_i = 1'b0;
        w0 = n_w;
        r0 = n_r;
        repeat (20) @(negedge clk);
        check("post_rst_no_strobe", 32'((n_w - w0) + (n_r - r0)), 32'd0);
        bus_cs_n_i = 1'b1;
        repeat (6) @(negedge clk);
        access(1'b0, 4'h6, 1'b0, 8'h66, 8, lat, nstb);
        check("post_rst_nstrobe", 32'(nstb), 32'd1);

        // Short CS pulse
`ifdef BUS_DEGLITCH_EN
        access(1'b0, 4'h8, 1'b0, 8'h88, 1, lat, nstb);
        check("glitch_nstrobe", 32'(nstb), 32'd0);
`else
        access(1'b0, 4'h8, 1'b0, 8'h88, 2, lat, nstb);
        check("short_nstrobe", 32'(nstb), 32'd1);
`endif

        // Back-to-back write then read
        w0 = n_w;
        r0 = n_r;
        rd_word_i = 16'h1234;
        bus_rd_nwr_i = 1'b0; bus_reg_num_i = 4'h9; bus_bytesel_i = 1'b1; bus_data_i = 8'hC3;
        repeat (3) @(negedge clk);
        bus_cs_n_i = 1'b0;
        repeat (5) @(negedge clk);
        bus_cs_n_i = 1'b1;
        bus_rd_nwr_i = 1'b1; bus_reg_num_i = 4'h7; bus_bytesel_i = 1'b0; bus_data_i = 8'h00;
        repeat (5) @(negedge clk);
        bus_cs_n_i = 1'b0;
        repeat (5) @(negedge clk);
        bus_cs_n_i = 1'b1;
        repeat (12) @(negedge clk);
        check("b2b_writes",  32'(n_w - w0), 32'd1);
        check("b2b_reads",   32'(n_r - r0), 32'd1);
        check("b2b_reg_num", 32'(reg_num_o), 32'h7);
        check("b2b_data",    32'(bus_data_o), 32'h12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
